// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
//
// Shared definitions for the tiny-TPU control blocks.
//
// Contents:
//   seq_state_t      - state encoding of the matmul job sequencer
//   TPU_N            - systolic array dimension (also the weight-load length)
//   TPU_FEED_CYCLES  - length of the activation-feed valid window (N+1)
//   TPU_DRAIN_CYCLES - idle cycles after the feed before results are final (N)
//   max3()           - constant helper used to size shared counters
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package tpu_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_W  = 3'd1,
      FEED    = 3'd2,
      DRAIN   = 3'd3,
      CAPTURE = 3'd4,
      DONE    = 3'd5
   } seq_state_t;

   localparam int TPU_N            = 2;
   localparam int TPU_FEED_CYCLES  = TPU_N + 1;
   localparam int TPU_DRAIN_CYCLES = TPU_N;

   // Largest of three integers; used at elaboration time to size a counter
   // that has to reach the longest of several phase lengths.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/matmul_sequencer.sv
// ---------------------------------------------------------------------------
// matmul_sequencer
//
// Control FSM that runs one 2x2 matrix-multiply job on the tiny-TPU datapath.
// A job is accepted over a valid/ready handshake, after which the block steps
// through weight load, activation feed, pipeline drain and result capture,
// finishing with a one-cycle done pulse. Only control strobes are produced;
// no data passes through this block.
//
// Parameters:
//   N            - array dimension; number of weight-load cycles
//   FEED_CYCLES  - cycles setup_valid is held high (skewed, zero-padded feed)
//   DRAIN_CYCLES - idle cycles after the feed; 0 skips the DRAIN state
//
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   cmd_valid      in   job request
//   cmd_ready      out  job can be accepted (state is IDLE)
//   abort          in   synchronous job cancel
//   weight_load    out  array latches weights
//   datapath_clear out  one-cycle clear of accumulators and input-setup counter
//   setup_valid    out  valid to the input-setup stage
//   result_capture out  output registers latch the array results
//   busy           out  high in every state except IDLE
//   done           out  one-cycle job-complete pulse
//   jobs_done      out  count of completed jobs, wraps 255 -> 0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module matmul_sequencer
   import tpu_pkg::*;
#(
   parameter int N            = TPU_N,
   parameter int FEED_CYCLES  = TPU_FEED_CYCLES,
   parameter int DRAIN_CYCLES = TPU_DRAIN_CYCLES
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       abort,
   output logic       weight_load,
   output logic       datapath_clear,
   output logic       setup_valid,
   output logic       result_capture,
   output logic       busy,
   output logic       done,
   output logic [7:0] jobs_done
);

   // One phase counter is shared by every state, so it must be wide enough to
   // reach the longest phase.
   localparam int CNT_MAX = max3(N, FEED_CYCLES, DRAIN_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // Counter value seen in the final cycle of each multi-cycle phase. The
   // drain value is meaningless when DRAIN_CYCLES is 0 because DRAIN is then
   // never entered.
   localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

   seq_state_t       state;
   seq_state_t       state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   // State and phase counter registers. The counter restarts from zero on
   // every state change so each phase measures its own length, and it is
   // parked at zero while waiting in IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic. An abort outside IDLE returns straight to IDLE; in IDLE
   // it also wins over a simultaneous request, so no job is started. The
   // feed phase skips DRAIN entirely when the build has no drain cycles.
   always_comb begin
      state_next = state;
      if (abort && (state != IDLE)) begin
         state_next = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid && !abort) state_next = LOAD_W;
            end
            LOAD_W: begin
               if (cnt == LOAD_LAST) state_next = FEED;
            end
            FEED: begin
               if (cnt == FEED_LAST) begin
                  if (DRAIN_CYCLES == 0) state_next = CAPTURE;
                  else                   state_next = DRAIN;
               end
            end
            DRAIN: begin
               if (cnt == DRAIN_LAST) state_next = CAPTURE;
            end
            CAPTURE: begin
               state_next = DONE;
            end
            DONE: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end

      if ((state_next != state) || (state == IDLE)) cnt_next = '0;
      else                                          cnt_next = cnt + 1'b1;
   end

   // Completed-job counter. It advances on the DONE cycle itself, so an abort
   // arriving in DONE does not undo a job that has already finished.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jobs_done <= 8'd0;
      end else if (state == DONE) begin
         jobs_done <= jobs_done + 8'd1;
      end
   end

   // Output decode from the registered state and counter only, so every
   // strobe is glitch-free relative to the clock and drops to its reset value
   // as soon as reset_n is asserted. The clear fires in the first weight-load
   // cycle, which puts it at least N cycles ahead of the first setup_valid.
   always_comb begin
      cmd_ready      = (state == IDLE);
      busy           = (state != IDLE);
      weight_load    = (state == LOAD_W);
      datapath_clear = (state == LOAD_W) && (cnt == '0);
      setup_valid    = (state == FEED);
      result_capture = (state == CAPTURE);
      done           = (state == DONE);
   end

endmodule

// File: tb/tb_matmul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_matmul_sequencer
//
// Directed bench for matmul_sequencer. A default-parameter instance covers
// single jobs, back-to-back jobs, abort handling, counter wrap and
// asynchronous reset; a second instance built with DRAIN_CYCLES=0 covers the
// shortened sequence. Expected strobe patterns are hand-tabulated per cycle,
// where cycle 0 is the cycle in which the request is accepted.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_matmul_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;

   logic       cmd_valid = 1'b0;
   logic       abort = 1'b0;
   logic       cmd_ready;
   logic       weight_load;
   logic       datapath_clear;
   logic       setup_valid;
   logic       result_capture;
   logic       busy;
   logic       done;
   logic [7:0] jobs_done;

   logic       cmd_valid_z = 1'b0;
   logic       abort_z = 1'b0;
   logic       cmd_ready_z;
   logic       weight_load_z;
   logic       datapath_clear_z;
   logic       setup_valid_z;
   logic       result_capture_z;
   logic       busy_z;
   logic       done_z;
   logic [7:0] jobs_done_z;

   int pass_count = 0;
   int total_count = 0;

   // Strobe bundle: {cmd_ready, busy, weight_load, datapath_clear,
   //                 setup_valid, result_capture, done}
   logic [6:0] strobes;
   logic [6:0] strobes_z;

   assign strobes   = {cmd_ready, busy, weight_load, datapath_clear,
                       setup_valid, result_capture, done};
   assign strobes_z = {cmd_ready_z, busy_z, weight_load_z, datapath_clear_z,
                       setup_valid_z, result_capture_z, done_z};

   matmul_sequencer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .abort          (abort),
      .weight_load    (weight_load),
      .datapath_clear (datapath_clear),
      .setup_valid    (setup_valid),
      .result_capture (result_capture),
      .busy           (busy),
      .done           (done),
      .jobs_done      (jobs_done)
   );

   matmul_sequencer #(
      .N            (2),
      .FEED_CYCLES  (3),
      .DRAIN_CYCLES (0)
   ) dut_z (
      .clk            (clk),
      .reset_n        (reset_n),
      .cmd_valid      (cmd_valid_z),
      .cmd_ready      (cmd_ready_z),
      .abort          (abort_z),
      .weight_load    (weight_load_z),
      .datapath_clear (datapath_clear_z),
      .setup_valid    (setup_valid_z),
      .result_capture (result_capture_z),
      .busy           (busy_z),
      .done           (done_z),
      .jobs_done      (jobs_done_z)
   );

   always #5 clk = ~clk;

   // Hard time limit so a stuck run still ends with a visible failure.
   initial begin
      #1000000;
      $display("[TB] FAIL timeout: simulation did not finish, pass=%0d total=%0d", pass_count, total_count);
      $fatal(1, "[TB] time limit reached");
   end

   // Advance to 1 ns after the next rising edge; inputs change and outputs
   // are sampled there, well away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      total_count++;
      assert (observed === expected) pass_count++;
      else $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, observed, expected);
   endtask

   // Hand-tabulated strobes for job cycle c (1..). With drain cycles the
   // sequence is LOAD_W 1-2, FEED 3-5, DRAIN 6-7, CAPTURE 8, DONE 9, IDLE 10;
   // without drain it is LOAD_W 1-2, FEED 3-5, CAPTURE 6, DONE 7, IDLE 8.
   function automatic logic [6:0] expected_strobes(input int c, input bit no_drain);
      logic [6:0] s;
      s = 7'b1000000;
      if (!no_drain) begin
         case (c)
            1:       s = 7'b0111000;
            2:       s = 7'b0110000;
            3, 4, 5: s = 7'b0100100;
            6, 7:    s = 7'b0100000;
            8:       s = 7'b0100010;
            9:       s = 7'b0100001;
            default: s = 7'b1000000;
         endcase
      end else begin
         case (c)
            1:       s = 7'b0111000;
            2:       s = 7'b0110000;
            3, 4, 5: s = 7'b0100100;
            6:       s = 7'b0100010;
            7:       s = 7'b0100001;
            default: s = 7'b1000000;
         endcase
      end
      return s;
   endfunction

   task automatic apply_reset();
      reset_n     = 1'b0;
      cmd_valid   = 1'b0;
      abort       = 1'b0;
      cmd_valid_z = 1'b0;
      abort_z     = 1'b0;
      step();
      step();
      check_output("reset strobes", 32'(strobes), 32'(7'b1000000));
      check_output("reset jobs_done", 32'(jobs_done), 32'd0);
      reset_n = 1'b1;
   endtask

   // Issues a one-cycle request in the current (IDLE) cycle and checks every
   // strobe through the return to IDLE, then the completed-job count.
   task automatic run_job(input bit no_drain, input logic [7:0] exp_jobs);
      int last_c;
      last_c = no_drain ? 8 : 10;
      if (no_drain) begin
         check_output("z accept ready", 32'(cmd_ready_z), 32'd1);
         cmd_valid_z = 1'b1;
      end else begin
         check_output("accept ready", 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b1;
      end
      step();
      cmd_valid   = 1'b0;
      cmd_valid_z = 1'b0;
      for (int c = 1; c <= last_c; c++) begin
         if (no_drain)
            check_output($sformatf("z job c%0d strobes", c), 32'(strobes_z),
                         32'(expected_strobes(c, 1'b1)));
         else
            check_output($sformatf("job c%0d strobes", c), 32'(strobes),
                         32'(expected_strobes(c, 1'b0)));
         if (c < last_c) step();
      end
      if (no_drain) check_output("z jobs_done", 32'(jobs_done_z), 32'(exp_jobs));
      else          check_output("jobs_done", 32'(jobs_done), 32'(exp_jobs));
   endtask

   initial begin
      int accepts;
      int bad_accepts;
      int dones;
      int feeds;

      $display("[TB] start");

      // Single job on each build.
      apply_reset();
      run_job(1'b0, 8'd1);
      run_job(1'b1, 8'd1);

      // Request held for three jobs: acceptance every 10 cycles.
      $display("[TB] back-to-back jobs");
      apply_reset();
      accepts = 0; bad_accepts = 0; dones = 0; feeds = 0;
      cmd_valid = 1'b1;
      for (int rel = 0; rel < 30; rel++) begin
         if (cmd_valid && cmd_ready) begin
            accepts++;
            if ((rel % 10) != 0) bad_accepts++;
         end
         if (done) dones++;
         if (setup_valid) feeds++;
         if (rel == 29) cmd_valid = 1'b0;
         step();
      end
      check_output("b2b accepts", 32'(accepts), 32'd3);
      check_output("b2b accept spacing", 32'(bad_accepts), 32'd0);
      check_output("b2b done pulses", 32'(dones), 32'd3);
      check_output("b2b feed cycles", 32'(feeds), 32'd9);
      check_output("b2b jobs_done", 32'(jobs_done), 32'd3);
      check_output("b2b idle after", 32'(strobes), 32'(7'b1000000));

      // Abort in cycle 4 (mid-feed).
      $display("[TB] abort mid-feed");
      apply_reset();
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      step();
      step();
      step();
      check_output("abort c4 setup_valid", 32'(setup_valid), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_output("abort c5 strobes", 32'(strobes), 32'(7'b1000000));
      check_output("abort jobs_done", 32'(jobs_done), 32'd0);
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) dones++;
         step();
      end
      check_output("abort no done", 32'(dones), 32'd0);
      run_job(1'b0, 8'd1);

      // Abort together with a request in IDLE is not accepted.
      $display("[TB] abort in idle");
      cmd_valid = 1'b1;
      abort     = 1'b1;
      step();
      cmd_valid = 1'b0;
      abort     = 1'b0;
      check_output("idle abort strobes", 32'(strobes), 32'(7'b1000000));
      run_job(1'b0, 8'd2);

      // Asynchronous reset in the middle of DRAIN.
      $display("[TB] async reset in drain");
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check_output("drain c6 strobes", 32'(strobes), 32'(7'b0100000));
      #2;
      reset_n = 1'b0;
      #1;
      check_output("async reset strobes", 32'(strobes), 32'(7'b1000000));
      check_output("async reset jobs_done", 32'(jobs_done), 32'd0);
      step();
      reset_n = 1'b1;
      step();

      // 256 jobs from reset wrap the job counter.
      $display("[TB] job counter wrap");
      apply_reset();
      cmd_valid = 1'b1;
      for (int rel = 0; rel < 2560; rel++) begin
         if (rel == 2550) check_output("wrap jobs 255", 32'(jobs_done), 32'd255);
         if (rel == 2559) cmd_valid = 1'b0;
         step();
      end
      check_output("wrap jobs 0", 32'(jobs_done), 32'd0);
      check_output("wrap idle strobes", 32'(strobes), 32'(7'b1000000));

      $display("%0d/%0d checks passed", pass_count, total_count);
      $finish;
   end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Control FSM that runs one 2x2 matrix-multiply job on the tiny-TPU datapath. It accepts a job over a valid/ready handshake, then drives the control strobes in order:
- weight load into the systolic array;
- clear of the accumulators and the skewing input-setup stage;
- the activation-feed `valid` window;
- the pipeline drain;
- result capture.

It sits between the host/command interface and the systolic array plus its input-setup stage. It touches only control signals, never data.

## Interface
- `N`, 2: array dimension; weight-load cycle count.
- `FEED_CYCLES`, 3 (`N`+1): cycles `setup_valid` is held high; covers the skewed, zero-padded activation stream.
- `DRAIN_CYCLES`, 2 (`N`): idle cycles after the feed, before results are final; 0 is legal and skips DRAIN.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: job request.
- `cmd_ready` out 1: job can be accepted.
- `abort` in 1: synchronous job cancel.
- `weight_load` out 1: array latches weights.
- `datapath_clear` out 1: one-cycle clear of the accumulators and input-setup counter.
- `setup_valid` out 1: `valid` to the input-setup stage.
- `result_capture` out 1: output registers latch the array results.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle job-complete pulse.
- `jobs_done` out 8: count of completed jobs; wraps.

## Operation
- States: IDLE, LOAD_W, FEED, DRAIN, CAPTURE, DONE.
- One phase counter `cnt` is shared by all states. It is sized `$clog2(max(N,FEED_CYCLES,DRAIN_CYCLES)+1)` and cleared on every state change.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid` && `cmd_ready` && !`abort`, go to LOAD_W.
- LOAD_W:
  - `weight_load`=1 for `N` cycles.
  - `datapath_clear`=1 only in the first LOAD_W cycle.
  - Go to FEED.
- FEED: `setup_valid`=1 for `FEED_CYCLES` cycles, then go to DRAIN (or to CAPTURE if `DRAIN_CYCLES`=0).
- DRAIN: all strobes low for `DRAIN_CYCLES` cycles, then go to CAPTURE.
- CAPTURE: `result_capture`=1 for one cycle, then go to DONE.
- DONE:
  - `done`=1 for one cycle.
  - `jobs_done` increments (255→0).
  - Go to IDLE.
- `abort` in any non-IDLE state:
  - Next state is IDLE.
  - All strobes are low from the next cycle on.
  - No `done` pulse; `jobs_done` is unchanged.
- `abort` has priority over acceptance in IDLE. `abort` in DONE still lets that cycle's `done` and increment stand, since they are registered from the current state.
- `cmd_valid` outside IDLE is ignored and not queued. The requester holds it until `cmd_ready`.
- All outputs are decoded from the registered state and `cnt`, except `cmd_ready`, which equals (state==IDLE).

## Timing
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, `cnt`=0, `jobs_done`=0.
  - `cmd_ready`=1.
  - All other outputs 0.
- Acceptance edge = cycle 0. With defaults:
  - cycles 1–2: LOAD_W, with `datapath_clear` in cycle 1;
  - cycles 3–5: FEED;
  - cycles 6–7: DRAIN;
  - cycle 8: CAPTURE;
  - cycle 9: DONE;
  - cycle 10: IDLE, `cmd_ready`=1.
- General formulas:
  - `done` cycle = `N`+`FEED_CYCLES`+`DRAIN_CYCLES`+2.
  - Back-to-back job period = `done` cycle + 1.
- `datapath_clear` always precedes the first `setup_valid` by ≥`N` cycles. The input-setup stage therefore restarts its element index at 0 for every job.
- `reset_n` low mid-job: outputs go to their reset values immediately, independent of `clk`.

## Structure
- Shared `tpu_pkg` holds:
  - `seq_state_t` enum (IDLE, LOAD_W, FEED, DRAIN, CAPTURE, DONE);
  - default constants `TPU_N`=2, `TPU_FEED_CYCLES`, `TPU_DRAIN_CYCLES`.
- Single module with no sub-modules. The phase counter and job counter are inline registers.

## Test plan
- Reset then a single `cmd_valid` pulse in IDLE → `weight_load` in cycles 1–2, `datapath_clear` in cycle 1 only, `setup_valid` in cycles 3–5, `result_capture` in cycle 8, `done` in cycle 9, `jobs_done`=1, `cmd_ready` high in cycle 10.
- `cmd_valid` held continuously for 3 jobs → accepts every 10 cycles, exactly 3 `done` pulses, `jobs_done`=3, each `setup_valid` window exactly 3 cycles.
- `abort` in cycle 4 (mid-FEED) → `setup_valid` low from cycle 5, IDLE in cycle 5, no `done`, `jobs_done` unchanged; a new job then runs the full sequence.
- `abort` and `cmd_valid` together in IDLE → not accepted, `busy` stays 0; `cmd_valid` alone next cycle → accepted.
- 256 completed jobs from reset → `jobs_done` wraps to 0. Build with `DRAIN_CYCLES`=0 → CAPTURE immediately follows the last FEED cycle, `done` in cycle 7.
- `reset_n` driven low between clock edges in DRAIN → all strobes 0 and `cmd_ready`=1 without waiting for a clock edge; `jobs_done`=0.
